cross_product_arbiter: RTL

//   Shares one pipelined signed cross-product/compare unit among NREQ geofence engines.

---
 rtl/geofence_pkg.sv | 21 ++
 rtl/cross_mul_pipe.sv | 162 ++++++++++++++++
 rtl/cross_product_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/geofence_pkg.sv
// Shared constants, FSM encoding and helpers for the geofence cross-product arbiter.
package geofence_pkg;

    localparam int CW_DEF   = 11;
    localparam int NREQ_MAX = 8;
    localparam int WD_LIMIT = 8;
    localparam int WD_W     = 4;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cross_mul_pipe.sv
// Pipelined signed cross product Ax*By - Ay*Bx reduced to sign flags, tagged with an id.
module cross_mul_pipe
    import geofence_pkg::*;
#(
    parameter int CW   = CW_DEF,
    parameter int PIPE = 2,
    parameter int IW   = 2
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] in_id,
    input  logic [CW-1:0] ax,
    input  logic [CW-1:0] ay,
    input  logic [CW-1:0] bx,
    input  logic [CW-1:0] by,
    output logic          out_valid,
    output logic [IW-1:0] out_id,
    output logic          out_pos,
    output logic          out_zero
);

    localparam int PW   = 2 * CW;
    localparam int DW   = 2 * CW + 1;
    localparam int PSTG = (PIPE >= 2) ? 2 : 1;  // stage at which products are available
    localparam int D    = PIPE - PSTG;          // pure delay stages after the compare

    logic [PIPE:0]          vld_pipe;
    logic [PIPE:1]          vld_q, vld_d;
    logic [PIPE:0][IW-1:0]  id_pipe;
    logic [PIPE:1][IW-1:0]  id_q, id_d;

    assign vld_pipe = {vld_q, in_valid};
    assign id_pipe  = {id_q, in_id};

    always_comb begin
        vld_d = vld_pipe[PIPE-1:0];
        id_d  = id_q;
        for (int k = 1; k <= PIPE; k++) begin
            if (vld_pipe[k-1]) id_d[k] = id_pipe[k-1];
        end
    end

    logic signed [CW-1:0] ax_q, ay_q, bx_q, by_q;
    logic signed [CW-1:0] ax_d, ay_d, bx_d, by_d;

    always_comb begin
        ax_d = ax_q;
        ay_d = ay_q;
        bx_d = bx_q;
        by_d = by_q;
        if (in_valid) begin
            ax_d = $signed(ax);
            ay_d = $signed(ay);
            bx_d = $signed(bx);
            by_d = $signed(by);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            id_q  <= '0;
            ax_q  <= '0;
            ay_q  <= '0;
            bx_q  <= '0;
            by_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            ax_q  <= ax_d;
            ay_q  <= ay_d;
            bx_q  <= bx_d;
            by_q  <= by_d;
        end
    end

    logic signed [PW-1:0] p1_c, p2_c, m1, m2;
    logic signed [DW-1:0] diff;
    logic                 pos_c, zero_c;

    assign p1_c = PW'(ax_q) * PW'(by_q);
    assign p2_c = PW'(ay_q) * PW'(bx_q);

    generate
        if (PIPE >= 2) begin : g_preg
            logic signed [PW-1:0] p1_q, p2_q, p1_d, p2_d;
            always_comb begin
                p1_d = p1_q;
                p2_d = p2_q;
                if (vld_pipe[1]) begin
                    p1_d = p1_c;
                    p2_d = p2_c;
                end
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p1_q <= '0;
                    p2_q <= '0;
                end else begin
                    p1_q <= p1_d;
                    p2_q <= p2_d;
                end
            end
            assign m1 = p1_q;
            assign m2 = p2_q;
        end else begin : g_pcomb
            assign m1 = p1_c;
            assign m2 = p2_c;
        end
    endgenerate

    // One extra bit so the difference of two extreme products cannot wrap.
    assign diff   = DW'(m1) - DW'(m2);
    assign zero_c = (diff == '0);
    assign pos_c  = !diff[DW-1] && !zero_c;

    assign out_valid = vld_pipe[PIPE];
    assign out_id    = id_q[PIPE];

    generate
        if (D == 0) begin : g_direct
            // Registers reset to zero look collinear; mask flags until a real result exists.
            logic seen_q, seen_d;
            assign seen_d = seen_q | vld_pipe[PIPE];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) seen_q <= 1'b0;
                else       seen_q <= seen_d;
            end
            assign out_pos  = pos_c  & seen_d;
            assign out_zero = zero_c & seen_d;
        end else begin : g_delay
            logic [D-1:0] pos_q, pos_d, zero_q, zero_d;
            always_comb begin
                pos_d  = pos_q;
                zero_d = zero_q;
                if (vld_pipe[PSTG]) begin
                    pos_d[0]  = pos_c;
                    zero_d[0] = zero_c;
                end
                for (int k = 1; k < D; k++) begin
                    if (vld_pipe[PSTG+k]) begin
                        pos_d[k]  = pos_q[k-1];
                        zero_d[k] = zero_q[k-1];
                    end
                end
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pos_q  <= '0;
                    zero_q <= '0;
                end else begin
                    pos_q  <= pos_d;
                    zero_q <= zero_d;
                end
            end
            assign out_pos  = pos_q[D-1];
            assign out_zero = zero_q[D-1];
        end
    endgenerate

endmodule

// File: rtl/cross_product_arbiter.sv
// Round-robin arbiter with per-engine lock sharing one cross-product/compare pipeline.
module cross_product_arbiter
    import geofence_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int CW   = CW_DEF,
    parameter  int PIPE = 2,
    localparam int IW   = clog2(NREQ)
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*CW-1:0] ax,
    input  logic [NREQ*CW-1:0] ay,
    input  logic [NREQ*CW-1:0] bx,
    input  logic [NREQ*CW-1:0] by,
    input  logic               hold,
    output logic [NREQ-1:0]    gnt,
    output logic               rsp_valid,
    output logic [IW-1:0]      rsp_id,
    output logic               rsp_pos,
    output logic               rsp_zero
);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [IW-1:0]     gnt_id;
    logic              gnt_any;

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        return i + 1'b1;
    endfunction

    function automatic int rr_idx(input logic [IW-1:0] p, input int off);
        return (int'(p) + off) % NREQ;
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wd_d    = wd_q;
        if (!hold) begin
            case (state_q)
                ST_ARB: begin
                    // Scan farthest-first so the request nearest ptr overrides.
                    for (int off = NREQ - 1; off >= 0; off--) begin
                        if (req[rr_idx(ptr_q, off)]) begin
                            gnt_any = 1'b1;
                            gnt_id  = IW'(rr_idx(ptr_q, off));
                        end
                    end
                    if (gnt_any) begin
                        gnt[gnt_id] = 1'b1;
                        ptr_d       = next_id(gnt_id);
                        if (lock[gnt_id]) begin
                            owner_d = gnt_id;
                            state_d = ST_OWNED;
                            wd_d    = '0;
                        end
                    end
                end
                ST_OWNED: begin
                    if (req[owner_q]) begin
                        gnt_any      = 1'b1;
                        gnt_id       = owner_q;
                        gnt[owner_q] = 1'b1;
                        wd_d         = '0;
                        if (!lock[owner_q]) begin
                            ptr_d   = next_id(owner_q);
                            state_d = ST_ARB;
                        end
                    end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                        wd_d    = '0;
                        ptr_d   = next_id(owner_q);
                        state_d = ST_ARB;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
        end
    end

    logic [CW-1:0] sel_ax, sel_ay, sel_bx, sel_by;

    always_comb begin
        sel_ax = '0;
        sel_ay = '0;
        sel_bx = '0;
        sel_by = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_ax = ax[i*CW +: CW];
                sel_ay = ay[i*CW +: CW];
                sel_bx = bx[i*CW +: CW];
                sel_by = by[i*CW +: CW];
            end
        end
    end

    cross_mul_pipe #(
        .CW   (CW),
        .PIPE (PIPE),
        .IW   (IW)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (gnt_any),
        .in_id     (gnt_id),
        .ax        (sel_ax),
        .ay        (sel_ay),
        .bx        (sel_bx),
        .by        (sel_by),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_pos   (rsp_pos),
        .out_zero  (rsp_zero)
    );

endmodule
